muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_if.sv | 28 ++
 rtl/muldiv_sequencer.sv | 279 +++++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/response bundle between the integer pipeline
// and the iterative multiply/divide sequencer. The master drives the operation
// request and the MTHI/MTLO writes. The slave returns busy/done and the HI/LO
// architectural registers.
interface muldiv_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 32-bit iterative multiply/divide unit that owns the HI/LO
// registers. Multiply uses a shift-add sequence. Divide uses a restoring
// shift-subtract sequence. Each sequence runs 32 steps, then one FIX cycle
// commits the result.
// Optional feature: define MULDIV_SIGNED_EN to enable the signed MULT/DIV
// variants (op[1]=1). When the macro is undefined, every operation is unsigned.
module muldiv_sequencer (
    input  logic                     clk,
    input  logic                     reset,
    muldiv_sequencer_if.slave        bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_q, opnd_d;    // multiplicand (mul) or divisor (div) magnitude
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic        accept_s;
    logic        div0_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [63:0] fix_s;
    logic [32:0] mul_sum_s;
    logic [63:0] mul_next_s;
    logic [32:0] div_diff_s;
    logic [63:0] div_next_s;

    // Start is honoured only when no operation is in flight.
    always_comb begin
        accept_s = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        div0_s   = accept_s && bus.op[0] && (bus.b == 32'h0000_0000);
    end

`ifdef MULDIV_SIGNED_EN
    logic signed_s;
    logic neg_res_q, neg_res_d;     // negate product (mul) or quotient (div)
    logic neg_rem_q, neg_rem_d;     // remainder follows the dividend sign
    logic is_div_q, is_div_d;

    // Take operand magnitudes and capture the result signs on accept.
    always_comb begin
        signed_s = bus.op[1];
        if (signed_s && bus.a[31]) begin
            a_mag_s = 32'h0000_0000 - bus.a;
        end else begin
            a_mag_s = bus.a;
        end
        if (signed_s && bus.b[31]) begin
            b_mag_s = 32'h0000_0000 - bus.b;
        end else begin
            b_mag_s = bus.b;
        end
        if (accept_s) begin
            neg_res_d = signed_s && (bus.a[31] ^ bus.b[31]);
            neg_rem_d = signed_s && bus.a[31];
            is_div_d  = bus.op[0];
        end else begin
            neg_res_d = neg_res_q;
            neg_rem_d = neg_rem_q;
            is_div_d  = is_div_q;
        end
    end

    // Sign correction applied in FIX to the unsigned iteration result.
    always_comb begin
        fix_s = acc_q;
        if (is_div_q) begin
            if (neg_rem_q) begin
                fix_s[63:32] = 32'h0000_0000 - acc_q[63:32];
            end else begin
                fix_s[63:32] = acc_q[63:32];
            end
            if (neg_res_q) begin
                fix_s[31:0] = 32'h0000_0000 - acc_q[31:0];
            end else begin
                fix_s[31:0] = acc_q[31:0];
            end
        end else begin
            if (neg_res_q) begin
                fix_s = 64'h0 - acc_q;
            end else begin
                fix_s = acc_q;
            end
        end
    end

    // Result-sign registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
        end
    end
`else
    logic unused_op1_s;

    // Unsigned only: operands pass through and FIX commits the accumulator as is.
    always_comb begin
        unused_op1_s = bus.op[1];
        a_mag_s      = bus.a;
        b_mag_s      = bus.b;
        fix_s        = acc_q;
    end
`endif

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        if (acc_q[0]) begin
            mul_sum_s = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
        end else begin
            mul_sum_s = {1'b0, acc_q[63:32]};
        end
        mul_next_s = {mul_sum_s, acc_q[31:1]};
        div_diff_s = acc_q[63:31] - {1'b0, opnd_q};
        if (div_diff_s[32]) begin
            div_next_s = {acc_q[62:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[31:0], acc_q[30:0], 1'b1};
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (div0_s) begin
                        state_d = ST_DONE;
                    end else if (bus.op[0]) begin
                        state_d = ST_DIV;
                    end else begin
                        state_d = ST_MUL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DIV: begin
                if (cnt_q == 5'd0) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_DIV;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight from flops.
    always_comb begin
        case (state_d)
            ST_MUL, ST_DIV, ST_FIX: begin
                busy_d = 1'b1;
                done_d = 1'b0;
            end
            ST_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
        dbz_d = div0_s;
    end

    // Datapath: operand latch, iteration, result commit and MTHI/MTLO writes.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opnd_d = opnd_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (accept_s) begin
            cnt_d = 5'd31;
            if (bus.op[0]) begin
                opnd_d = b_mag_s;
                acc_d  = {32'h0000_0000, a_mag_s};
            end else begin
                opnd_d = a_mag_s;
                acc_d  = {32'h0000_0000, b_mag_s};
            end
            if (div0_s) begin
                hi_d = bus.a;
                lo_d = 32'hFFFF_FFFF;
            end else begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        end else if ((state_q == ST_MUL) || (state_q == ST_DIV)) begin
            if (state_q == ST_MUL) begin
                acc_d = mul_next_s;
            end else begin
                acc_d = div_next_s;
            end
            if (cnt_q == 5'd0) begin
                cnt_d = 5'd0;
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end else if (state_q == ST_FIX) begin
            hi_d = fix_s[63:32];
            lo_d = fix_s[31:0];
        end else if ((state_q == ST_IDLE) || (state_q == ST_DONE)) begin
            if (bus.hi_we) begin
                hi_d = bus.wdata;
            end else begin
                hi_d = hi_q;
            end
            if (bus.lo_we) begin
                lo_d = bus.wdata;
            end else begin
                lo_d = lo_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'h0;
            opnd_q  <= 32'h0000_0000;
            hi_q    <= 32'h0000_0000;
            lo_q    <= 32'h0000_0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: random and directed operations checked against an
// arithmetic reference model (64-bit products, native / and %).
module tb_muldiv_sequencer;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] hi_exp;
    logic [31:0] lo_exp;

    muldiv_sequencer_if bus_if ();

    muldiv_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        logic [63:0] p;
        longint sa, sb, q, r;
        z = 1'b0;
        sa = 0; sb = 0; q = 0; r = 0; p = 64'h0;
        if (op[0] && (b == 32'h0)) begin
            h = a;
            l = 32'hFFFF_FFFF;
            z = 1'b1;
        end
`ifdef MULDIV_SIGNED_EN
        else if (op[1]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            if (op[0]) begin
                q = sa / sb;
                r = sa % sb;
                l = q[31:0];
                h = r[31:0];
            end else begin
                q = sa * sb;
                h = q[63:32];
                l = q[31:0];
            end
        end
`endif
        else if (op[0]) begin
            l = a / b;
            h = a % b;
        end else begin
            p = {32'h0, a} * {32'h0, b};
            h = p[63:32];
            l = p[31:0];
        end
    endfunction

    // Issue one operation; optionally a same-edge MTHI/MTLO (must be dropped)
    // and a mid-flight start+MTHI at cycle k+10 (must be ignored).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit same_edge_wr, input bit inject);
        logic [31:0] eh, el;
        logic ez;
        int busy_cnt, done_at;
        bit stable;
        model(op, a, b, eh, el, ez);
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.hi_we = same_edge_wr;
        bus_if.lo_we = same_edge_wr;
        bus_if.wdata = $urandom;
        @(negedge clk);
        bus_if.start = 1'b0;
        bus_if.hi_we = 1'b0;
        bus_if.lo_we = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        stable   = 1'b1;
        for (int j = 1; (j <= 40) && (done_at == 0); j++) begin
            if (j == 11) begin
                bus_if.start = 1'b0;
                bus_if.hi_we = 1'b0;
            end
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done) done_at = j;
            else if ((bus_if.hi !== hi_exp) || (bus_if.lo !== lo_exp)) stable = 1'b0;
            if (inject && (j == 10)) begin
                bus_if.start = 1'b1;
                bus_if.op    = 2'($urandom);
                bus_if.a     = $urandom;
                bus_if.b     = $urandom;
                bus_if.hi_we = 1'b1;
                bus_if.wdata = 32'h0000_DEAD;
            end
            if (done_at == 0) @(negedge clk);
        end
        chk("latency", done_at, ez ? 1 : 34);
        chk("busy_cycles", busy_cnt, ez ? 0 : 33);
        chk("hi_held", stable, 1);
        chk("hi", bus_if.hi, eh);
        chk("lo", bus_if.lo, el);
        chk("div_by_zero", bus_if.div_by_zero, ez);
        hi_exp = eh;
        lo_exp = el;
        @(negedge clk);
        chk("done_single", bus_if.done, 1'b0);
    endtask

    task automatic mtx(input logic hwe, input logic lwe, input logic [31:0] d);
        @(negedge clk);
        bus_if.hi_we = hwe;
        bus_if.lo_we = lwe;
        bus_if.wdata = d;
        @(negedge clk);
        bus_if.hi_we = 1'b0;
        bus_if.lo_we = 1'b0;
        if (hwe) hi_exp = d;
        if (lwe) lo_exp = d;
        chk("mt_hi", bus_if.hi, hi_exp);
        chk("mt_lo", bus_if.lo, lo_exp);
    endtask

    initial begin
        logic [1:0] rop;
        logic [31:0] ra, rb;
        bit rdone;
        total = 0;
        bad   = 0;
        hi_exp = 32'h0;
        lo_exp = 32'h0;
        bus_if.start = 1'b0;
        bus_if.op    = 2'b00;
        bus_if.a     = 32'h0;
        bus_if.b     = 32'h0;
        bus_if.hi_we = 1'b0;
        bus_if.lo_we = 1'b0;
        bus_if.wdata = 32'h0;
        reset = 1'b1;
        #1;
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_done", bus_if.done, 1'b0);
        chk("rst_hi", bus_if.hi, 32'h0);
        chk("rst_lo", bus_if.lo, 32'h0);
        chk("rst_dbz", bus_if.div_by_zero, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed corner cases.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(2'b01, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(2'b01, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        run_op(2'b01, 32'h0000_5555, 32'h0, 1'b1, 1'b0);
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
        mtx(1'b1, 1'b0, 32'h0000_DEAD);
        mtx(1'b0, 1'b1, 32'hBEEF_0001);
        run_op(2'b00, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
`ifdef MULDIV_SIGNED_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif

        // Reset in the middle of a divide.
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.op    = 2'b01;
        bus_if.a     = 32'hFFFF_0000;
        bus_if.b     = 32'd13;
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", bus_if.busy, 1'b0);
        chk("abort_hi", bus_if.hi, 32'h0);
        chk("abort_lo", bus_if.lo, 32'h0);
        hi_exp = 32'h0;
        lo_exp = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        rdone = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_if.done) rdone = 1'b1;
        end
        chk("abort_no_done", rdone, 1'b0);
        run_op(2'b01, 32'd9, 32'd3, 1'b0, 1'b0);

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 1'($urandom), 1'($urandom_range(0, 3) == 0));
            if ((n % 6) == 5) mtx(1'($urandom), 1'($urandom), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
